spl_multi: RTL
==============

// Module: spl_multi
// PURPOSE
//  Multi-channel sound-pressure-level meter: per-channel peak hold, hold timer, then linear decay.
//  Takes time-multiplexed signed samples (one channel per cycle) from the mic/decimator chain.
//  Drives display/telemetry through a registered random-access read port (peak + log level code).
// PARAMETERS
//  W          16  sample width, signed two's complement; peak magnitude also W bits
//  CHANS      4   number of channels (>=1); CH_W = max(1,$clog2(CHANS)) local
//  HOLD       8   decay_en ticks a new peak is held before decay starts (0 = no hold)
//  DECAY_STEP 1   amount subtracted from peak per decay tick once hold expires
//  LVL_W      local = $clog2(W); level code width (4 for W=16)
// PORTS
//  ck        in   1      clock
//  rst_n     in   1      asynchronous reset, active low
//  clear     in   1      sync clear of all peaks and hold counters
//  in_valid  in   1      sample strobe
//  in_chan   in   CH_W   channel of sample
//  in        in   W      signed sample
//  decay_en  in   1      decay tick, applies to all channels
//  rd_en     in   1      read request
//  rd_chan   in   CH_W   channel to read
//  rd_valid  out  1      read data valid (1 cycle after rd_en)
//  rd_peak   out  W      peak magnitude of rd_chan
//  rd_level  out  LVL_W  level code of rd_peak
// BEHAVIOUR
//  Reset (rst_n=0, async): all peak=0, hold=0, rd_valid=0, rd_peak=0, rd_level=all-ones.
//  clear=1: same state as reset on next edge; overrides sample and decay that cycle; read unaffected.
//  Magnitude: mag = in[W-1] ? -in : in; most-negative input saturates to 2^(W-1)-1.
//  Sample (in_valid, in_chan<CHANS): if mag >= peak[ch]: peak<=mag, hold<=HOLD; else no change.
//  in_chan >= CHANS: sample ignored.
//  Decay (decay_en), each channel: hold!=0 -> hold-1; hold==0 -> peak <= (peak>DECAY_STEP) ? peak-DECAY_STEP : 0.
//  Peak never wraps below 0; hold never wraps.
//  Sample and decay on same cycle, addressed channel: sample update wins when mag >= peak, otherwise decay applies.
//  Other channels decay normally.
//  Read: rd_en -> next cycle rd_valid=1, rd_peak/rd_level registered from state before that edge's update.
//  No rd_en -> rd_valid=0; rd_peak/rd_level hold last value.
//  rd_chan >= CHANS: rd_valid=1, rd_peak=0, rd_level=all-ones.
//  Level code: leading zeros of rd_peak[W-2:0], clamped to 2^LVL_W-1.
//  W=16 examples: 0x4000->0, 0x0001->14, 0x0000->15.
//  State: 2 symbolic read states IDLE/VALID (rd_valid reg); per-channel peak/hold arrays are flops.
// CONFIGURATION
//  SPL_MULTI_LEVEL_EN defined: rd_level computed as above, registered with rd_peak.
//  Not defined: encoder removed; rd_level tied to 0 at all times, including in reset.
// STRUCTURE
//  spl_defs.vh: LVL_W/CH_W clog2 helper functions and a MAG_MAX(W) constant macro.
//  Sub-module spl_level_enc (W in, LVL_W out, combinational leading-zero count).
//  Instantiated only under SPL_MULTI_LEVEL_EN.
//  Peak/hold arrays and update logic stay in spl_multi.
// TESTING
//  1. Reset, then in=0x4000 on ch1, rd ch1 -> rd_peak=0x4000, rd_level=0; ch0/2/3 read 0, level 15.
//  2. HOLD=8, DECAY_STEP=1: after peak 0x4000, 8 decay ticks -> 0x4000; ticks 9..12 -> 0x3fff..0x3ffc.
//  3. Decay from 0x0002: ticks -> 0x0001, 0x0000, 0x0000 (no wrap); decay_en=0 holds value.
//  4. ch2: in=-i then +i for i=0..0x7ff6 step 10 -> rd_peak=i after each; in=0x8000 -> rd_peak=0x7fff.
//  5. Same-cycle: peak 0x0100, decay_en with in=0x0080 -> 0x00ff; decay_en with in=0x0200 -> 0x0200, hold reloaded.
//  6. Async rst_n pulse mid-stream; clear=1 with in_valid=1 -> all peaks 0. rd_chan=CHANS -> rd_valid=1, peak 0.

Source files
------------

// File: rtl/spl_multi_pkg.sv
// Shared types and width helpers for the multi-channel SPL meter.
package spl_multi_pkg;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_VALID = 1'b1
  } rd_state_t;

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int lvl_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // Counter width able to hold the value n itself (at least one bit)
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spl_level_enc.sv
// Level code encoder: leading zeros of peak[W-2:0], clamped to the all-ones code.
module spl_level_enc #(
  parameter int W     = 16,
  parameter int LVL_W = 4
) (
  input  logic [W-1:0]     peak,
  output logic [LVL_W-1:0] level
);
  localparam int MAXL = (1 << LVL_W) - 1;

  int   cnt;
  logic unused_msb;

  // Ascending scan: the highest set bit is the last to write cnt
  always_comb begin
    cnt = W - 1;
    for (int i = 0; i <= W - 2; i++) begin
      if (peak[i]) cnt = W - 2 - i;
    end
  end

  assign level      = (cnt > MAXL) ? LVL_W'(MAXL) : LVL_W'(cnt);
  assign unused_msb = peak[W-1];

endmodule

// File: rtl/spl_multi.sv
// Multi-channel SPL meter: per-channel peak hold, hold timer, linear decay, registered read port.
// Optional level encoder enabled by defining SPL_MULTI_LEVEL_EN; otherwise rd_level is tied to 0.
//
//  state    | meaning
//  RD_IDLE  | no read data presented, rd_valid=0
//  RD_VALID | read data registered last cycle, rd_valid=1
module spl_multi
  import spl_multi_pkg::*;
#(
  parameter  int W          = 16,
  parameter  int CHANS      = 4,
  parameter  int HOLD       = 8,
  parameter  int DECAY_STEP = 1,
  localparam int CH_W       = ch_width(CHANS),
  localparam int LVL_W      = lvl_width(W)
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  in_chan,
  input  logic [W-1:0]     in,
  input  logic             decay_en,
  input  logic             rd_en,
  input  logic [CH_W-1:0]  rd_chan,
  output logic             rd_valid,
  output logic [W-1:0]     rd_peak,
  output logic [LVL_W-1:0] rd_level
);
  localparam int              HW       = cnt_width(HOLD);
  localparam logic [HW-1:0]   HOLD_V   = HW'(HOLD);
  localparam logic [W-1:0]    STEP     = W'(DECAY_STEP);
  localparam logic [W-1:0]    MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]    MAG_MAX  = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0]  peak_q [CHANS];
  logic [W-1:0]  peak_d [CHANS];
  logic [HW-1:0] hold_q [CHANS];
  logic [HW-1:0] hold_d [CHANS];
  logic [W-1:0]  mag;
  logic [W-1:0]  sel_peak;
  rd_state_t     state_q, state_d;

  // Most-negative input has no positive counterpart in W bits, so it saturates
  always_comb begin
    if (in == MOST_NEG)  mag = MAG_MAX;
    else if (in[W-1])    mag = -in;
    else                 mag = in;
  end

  // Out-of-range in_chan matches no channel and is dropped naturally
  always_comb begin
    for (int c = 0; c < CHANS; c++) begin
      peak_d[c] = peak_q[c];
      hold_d[c] = hold_q[c];
      if (clear) begin
        peak_d[c] = '0;
        hold_d[c] = '0;
      end else if (in_valid && (in_chan == CH_W'(c)) && (mag >= peak_q[c])) begin
        peak_d[c] = mag;
        hold_d[c] = HOLD_V;
      end else if (decay_en) begin
        if (hold_q[c] != '0) hold_d[c] = hold_q[c] - HW'(1);
        else                 peak_d[c] = (peak_q[c] > STEP) ? peak_q[c] - STEP : '0;
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANS; c++) begin
        peak_q[c] <= '0;
        hold_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANS; c++) begin
        peak_q[c] <= peak_d[c];
        hold_q[c] <= hold_d[c];
      end
    end
  end

  always_comb begin
    sel_peak = '0;
    for (int c = 0; c < CHANS; c++) begin
      if (rd_chan == CH_W'(c)) sel_peak = peak_q[c];
    end
  end

  always_comb begin
    state_d = rd_en ? RD_VALID : RD_IDLE;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) state_q <= RD_IDLE;
    else        state_q <= state_d;
  end

  assign rd_valid = (state_q == RD_VALID);

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)     rd_peak <= '0;
    else if (rd_en) rd_peak <= sel_peak;
  end

`ifdef SPL_MULTI_LEVEL_EN
  logic [LVL_W-1:0] sel_level;

  spl_level_enc #(
    .W     (W),
    .LVL_W (LVL_W)
  ) u_level_enc (
    .peak  (sel_peak),
    .level (sel_level)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)     rd_level <= '1;
    else if (rd_en) rd_level <= sel_level;
  end
`else
  assign rd_level = '0;
`endif

endmodule
